ser2par_hs: RTL

Parametrised serial-to-parallel converter for the byte-receive path: the next generation of the basic shifter.
- Samples SerDataIn on every rising Clk edge where SerDataEn is high.
- Bit order is selectable: LSB-first or MSB-first.
- Each completed word is presented on a one-deep output register with a valid/ready handshake.
- Flags an incomplete frame (enable dropped mid-word) and an overrun (new word arrives while the previous one is unconsumed).

---
 rtl/ser2par_hs.sv | 97 +++++++++
 1 files changed

// File: rtl/ser2par_hs.sv
// Serial-to-parallel receiver with a one-deep valid/ready output register.
// It also reports frame errors (a word cut short) and overruns (a word dropped).
module ser2par_hs #(
  parameter int bitlen   = 8,
  parameter bit MsbFirst = 1'b0
) (
  input  logic                             Clk,
  input  logic                             RstB,
  input  logic                             SerDataIn,
  input  logic                             SerDataEn,
  output logic [bitlen-1:0]                ParDataOut,
  output logic                             ParDataValid,
  input  logic                             ParDataReady,
  output logic                             FrameErr,
  output logic                             Overrun,
  input  logic                             OvrClr,
  output logic [$clog2(bitlen+1)-1:0]      BitCnt
);
  localparam int CW = $clog2(bitlen+1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t            state;
  logic [bitlen-1:0] sreg;
  logic [bitlen-1:0] shNext;
  logic              lastBit;
  logic              complete;

  // shNext is the shift register after the current bit is taken in.
  // On the last bit of a word it is also the completed word.
  generate
    if (MsbFirst) begin : g_msb
      assign shNext = {sreg[bitlen-2:0], SerDataIn};
    end else begin : g_lsb
      assign shNext = {SerDataIn, sreg[bitlen-1:1]};
    end
  endgenerate

  assign lastBit  = (state == SHIFT) && (BitCnt == CW'(bitlen-1));
  assign complete = SerDataEn && lastBit;

  always_ff @(posedge Clk or negedge RstB) begin
    if (!RstB) begin
      state        <= IDLE;
      sreg         <= '0;
      BitCnt       <= '0;
      ParDataOut   <= '0;
      ParDataValid <= 1'b0;
      FrameErr     <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      FrameErr <= 1'b0;
      case (state)
        IDLE: begin
          if (SerDataEn) begin
            sreg   <= shNext;
            BitCnt <= CW'(1);
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (!SerDataEn) begin
            sreg     <= '0;
            BitCnt   <= '0;
            state    <= IDLE;
            FrameErr <= 1'b1;
          end else if (lastBit) begin
            sreg   <= '0;
            BitCnt <= '0;
            state  <= IDLE;
          end else begin
            sreg   <= shNext;
            BitCnt <= BitCnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // A word that completes while the previous word is consumed on the same edge
      // replaces it with no bubble. A word that completes while the previous word
      // is still held is dropped.
      if (complete) begin
        if (!ParDataValid || ParDataReady) begin
          ParDataOut   <= shNext;
          ParDataValid <= 1'b1;
        end
      end else if (ParDataValid && ParDataReady) begin
        ParDataValid <= 1'b0;
      end

      if (complete && ParDataValid && !ParDataReady)
        Overrun <= 1'b1;
      else if (OvrClr)
        Overrun <= 1'b0;
    end
  end
endmodule
